// File: rtl/nmc_pkg.sv
// Shared types for the near-memory RMW Avalon slave: op codes, FSM states
// and the location of the op field in the Avalon address.
package nmc_pkg;

  localparam int OP_W = 2;

  typedef enum logic [1:0] {
    NMC_WRITE  = 2'b00,
    NMC_ADD    = 2'b01,
    NMC_MAX    = 2'b10,
    NMC_SATADD = 2'b11
  } nmc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RMW_WAIT = 2'b01,
    ST_RMW_WR   = 2'b10
  } nmc_state_e;

  // The op code occupies the top OP_W bits of the Avalon address.
  function automatic int op_lsb(input int av_addr_w);
    return av_addr_w - OP_W;
  endfunction

endpackage

// File: rtl/nmc_lane_alu.sv
// One arithmetic lane: combines the old SRAM lane (a) with the write data
// lane (b); clip flags a SATADD that had to saturate.
module nmc_lane_alu
  import nmc_pkg::*;
#(
  parameter int LANE_W = 32
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  nmc_op_e           op,
  output logic [LANE_W-1:0] result,
  output logic              clip
);

  logic [LANE_W:0] sum_s;
  logic            ovf_s;

  assign sum_s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
  assign ovf_s = sum_s[LANE_W] ^ sum_s[LANE_W-1];

  // Per-op lane result; saturation direction follows the true sign bit.
  always_comb begin
    result = b;
    clip   = 1'b0;
    case (op)
      NMC_WRITE: result = b;
      NMC_ADD:   result = sum_s[LANE_W-1:0];
      NMC_MAX:   result = ($signed(a) > $signed(b)) ? a : b;
      NMC_SATADD: begin
        if (ovf_s) begin
          clip   = 1'b1;
          result = sum_s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
        end else begin
          result = sum_s[LANE_W-1:0];
        end
      end
      default:   result = b;
    endcase
  end

endmodule

// File: rtl/avalon_nmc_rmw.sv
// Avalon-MM slave in front of a single-port SRAM with pipelined reads and
// per-lane read-modify-write ops (ADD, MAX, saturating ADD).
module avalon_nmc_rmw
  import nmc_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int LANE_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int AV_ADDR_W = 64,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [AV_ADDR_W-1:0]   AvalonAddr_i,
  input  logic                   AvalonRead_i,
  input  logic                   AvalonWrite_i,
  input  logic [DATA_W/8-1:0]    AvalonByteEnable_i,
  input  logic [DATA_W-1:0]      AvalonWriteData_i,
  output logic [DATA_W-1:0]      AvalonReadData_o,
  output logic                   AvalonReadDataValid_o,
  output logic                   AvalonWaitReq_o,
  output logic [ADDR_W-1:0]      SramAddr_o,
  output logic                   SramRdEn_o,
  output logic                   SramWrEn_o,
  output logic [DATA_W/8-1:0]    SramByteEnable_o,
  output logic [DATA_W-1:0]      SramWriteData_o,
  input  logic [DATA_W-1:0]      SramReadData_i,
  input  logic                   SatClr_i,
  output logic                   Sat_o
);

  localparam int LANES  = DATA_W / LANE_W;
  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_B = LANE_W / 8;
  localparam int OP_LSB = op_lsb(AV_ADDR_W);
  localparam int CNT_W  = 2;

  nmc_state_e        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              live_r;
  logic              cap_en_s;
  logic [ADDR_W-1:0] cap_addr_r;
  nmc_op_e           cap_op_r;
  logic [BE_W-1:0]   cap_be_r;
  logic [DATA_W-1:0] cap_wd_r;
  logic [RD_LAT-1:0] vld_r;
  logic              rd_acc_s;
  logic              sat_r;
  logic              sat_set_s;
  logic [DATA_W-1:0] alu_res_s;
  logic [LANES-1:0]  lane_clip_s;
  logic [LANES-1:0]  lane_en_s;
  nmc_op_e           wr_op_s;
  logic              unused_s;

  assign wr_op_s  = nmc_op_e'(AvalonAddr_i[AV_ADDR_W-1 -: OP_W]);
  assign unused_s = ^AvalonAddr_i[OP_LSB-1:ADDR_W];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    nmc_lane_alu #(.LANE_W(LANE_W)) u_alu (
      .a      (SramReadData_i[g*LANE_W +: LANE_W]),
      .b      (cap_wd_r[g*LANE_W +: LANE_W]),
      .op     (cap_op_r),
      .result (alu_res_s[g*LANE_W +: LANE_W]),
      .clip   (lane_clip_s[g])
    );
    assign lane_en_s[g] = |cap_be_r[g*LANE_B +: LANE_B];
  end

  // Next state and SRAM/Avalon strobes; live_r holds off traffic until reset has settled.
  always_comb begin
    state_s          = state_r;
    cnt_s            = cnt_r;
    cap_en_s         = 1'b0;
    rd_acc_s         = 1'b0;
    AvalonWaitReq_o  = 1'b1;
    SramRdEn_o       = 1'b0;
    SramWrEn_o       = 1'b0;
    SramAddr_o       = '0;
    SramByteEnable_o = '0;
    SramWriteData_o  = '0;
    case (state_r)
      ST_IDLE: begin
        if (!live_r) begin
          AvalonWaitReq_o = 1'b1;
        end else if (AvalonWrite_i) begin
          SramAddr_o = AvalonAddr_i[ADDR_W-1:0];
          if (wr_op_s == NMC_WRITE) begin
            AvalonWaitReq_o  = 1'b0;
            SramWrEn_o       = 1'b1;
            SramByteEnable_o = AvalonByteEnable_i;
            SramWriteData_o  = AvalonWriteData_i;
          end else begin
            SramRdEn_o = 1'b1;
            cap_en_s   = 1'b1;
            if (RD_LAT > 1) begin
              state_s = ST_RMW_WAIT;
              cnt_s   = CNT_W'(RD_LAT - 2);
            end else begin
              state_s = ST_RMW_WR;
            end
          end
        end else if (AvalonRead_i) begin
          AvalonWaitReq_o = 1'b0;
          SramRdEn_o      = 1'b1;
          SramAddr_o      = AvalonAddr_i[ADDR_W-1:0];
          rd_acc_s        = 1'b1;
        end else begin
          AvalonWaitReq_o = 1'b0;
        end
      end
      ST_RMW_WAIT: begin
        SramAddr_o = cap_addr_r;
        if (cnt_r == '0) begin
          state_s = ST_RMW_WR;
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      ST_RMW_WR: begin
        AvalonWaitReq_o  = 1'b0;
        SramWrEn_o       = 1'b1;
        SramAddr_o       = cap_addr_r;
        SramByteEnable_o = cap_be_r;
        SramWriteData_o  = alu_res_s;
        state_s          = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  assign sat_set_s = (state_r == ST_RMW_WR) && (cap_op_r == NMC_SATADD) && |(lane_clip_s & lane_en_s);

  // FSM state, wait counter and post-reset enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      live_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      live_r  <= 1'b1;
    end
  end

  // Held op-write command.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_addr_r <= '0;
      cap_op_r   <= NMC_WRITE;
      cap_be_r   <= '0;
      cap_wd_r   <= '0;
    end else if (cap_en_s) begin
      cap_addr_r <= AvalonAddr_i[ADDR_W-1:0];
      cap_op_r   <= wr_op_s;
      cap_be_r   <= AvalonByteEnable_i;
      cap_wd_r   <= AvalonWriteData_i;
    end
  end

  // Read-valid shift register and sticky saturation flag (set beats clear).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_r <= '0;
      sat_r <= 1'b0;
    end else begin
      vld_r <= (vld_r << 1) | RD_LAT'(rd_acc_s);
      if (sat_set_s) begin
        sat_r <= 1'b1;
      end else if (SatClr_i) begin
        sat_r <= 1'b0;
      end
    end
  end

  assign AvalonReadDataValid_o = vld_r[RD_LAT-1];
  assign AvalonReadData_o      = vld_r[RD_LAT-1] ? SramReadData_i : '0;
  assign Sat_o                 = sat_r;

endmodule

// File: tb/tb_avalon_nmc_rmw.sv
// Bench for avalon_nmc_rmw: three DUTs (RD_LAT 1..3) share one SRAM model,
// checked by table vectors, hand sequences and random traffic vs a lane model.
module tb_avalon_nmc_rmw;
  import nmc_pkg::*;

  localparam int DW = 128, LW = 32, AW = 9, AVW = 64, BEW = DW / 8, NL = DW / LW, NI = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int sel = 0;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic [AVW-1:0] av_addr = '0;
  logic           av_rd = 1'b0, av_wr = 1'b0, sat_clr = 1'b0;
  logic [BEW-1:0] av_be = '0;
  logic [DW-1:0]  av_wd = '0;

  logic [DW-1:0]  rdata_a [NI];
  logic           rvalid_a [NI], wait_a [NI], rden_a [NI], wren_a [NI], sat_a [NI];
  logic [AW-1:0]  saddr_a [NI];
  logic [BEW-1:0] sbe_a [NI];
  logic [DW-1:0]  swd_a [NI];
  logic [DW-1:0]  q_pipe [4];
  logic [DW-1:0]  mem [512];
  logic [DW-1:0]  ref_mem [512];
  logic           exp_sat [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    avalon_nmc_rmw #(.DATA_W(DW), .LANE_W(LW), .ADDR_W(AW), .AV_ADDR_W(AVW), .RD_LAT(k + 1)) u_dut (
      .clk                   (clk),
      .rstn                  (rstn),
      .AvalonAddr_i          (av_addr),
      .AvalonRead_i          (av_rd && (sel == k)),
      .AvalonWrite_i         (av_wr && (sel == k)),
      .AvalonByteEnable_i    (av_be),
      .AvalonWriteData_i     (av_wd),
      .AvalonReadData_o      (rdata_a[k]),
      .AvalonReadDataValid_o (rvalid_a[k]),
      .AvalonWaitReq_o       (wait_a[k]),
      .SramAddr_o            (saddr_a[k]),
      .SramRdEn_o            (rden_a[k]),
      .SramWrEn_o            (wren_a[k]),
      .SramByteEnable_o      (sbe_a[k]),
      .SramWriteData_o       (swd_a[k]),
      .SramReadData_i        (q_pipe[k]),
      .SatClr_i              (sat_clr && (sel == k)),
      .Sat_o                 (sat_a[k])
    );
  end

  logic [DW-1:0] cur_rdata;
  logic          cur_rvalid, cur_wait, cur_wren, cur_sat;
  assign cur_rdata  = rdata_a[sel];
  assign cur_rvalid = rvalid_a[sel];
  assign cur_wait   = wait_a[sel];
  assign cur_wren   = wren_a[sel];
  assign cur_sat    = sat_a[sel];

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                                input logic [BEW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BEW; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // SRAM model: byte-masked write, read data delayed by a 4-deep pipe tapped per DUT.
  always @(posedge clk) begin
    if (wren_a[sel]) mem[saddr_a[sel]] <= merge_bytes(mem[saddr_a[sel]], swd_a[sel], sbe_a[sel]);
    q_pipe[0] <= rden_a[sel] ? mem[saddr_a[sel]] : '0;
    q_pipe[1] <= q_pipe[0];
    q_pipe[2] <= q_pipe[1];
    q_pipe[3] <= q_pipe[2];
    cyc <= cyc + 1;
  end

  task automatic check_vec(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_exp_t;
  rd_exp_t rdq[$];

  // Read-return monitor: each valid must match the oldest outstanding read, on its due cycle.
  always @(negedge clk) begin
    rd_exp_t e;
    if (rstn && cur_rvalid) begin
      if (rdq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: valid with data %h but no read outstanding", cur_rdata);
      end else begin
        e = rdq.pop_front();
        check_int("rd_cycle", cyc, e.due);
        check_vec("rd_data", cur_rdata, e.data);
      end
    end
  end

  // Lane-level reference: signed arithmetic on integers, then the byte mask.
  function automatic void ref_rmw(input logic [1:0] op, input logic [DW-1:0] old_w, input logic [DW-1:0] wd,
                                  input logic [BEW-1:0] be, output logic [DW-1:0] new_w, output logic clipped);
    longint a, b, r, maxv, minv;
    logic [DW-1:0] full;
    maxv = (longint'(1) <<< (LW - 1)) - 1;
    minv = -(longint'(1) <<< (LW - 1));
    clipped = 1'b0;
    full = '0;
    for (int l = 0; l < NL; l++) begin
      a = longint'($signed(old_w[l*LW +: LW]));
      b = longint'($signed(wd[l*LW +: LW]));
      case (op)
        2'd1: r = a + b;
        2'd2: r = (a > b) ? a : b;
        2'd3: begin
          r = a + b;
          if (r > maxv || r < minv) begin
            r = (r > maxv) ? maxv : minv;
            if (|be[l*(LW/8) +: LW/8]) clipped = 1'b1;
          end
        end
        default: r = b;
      endcase
      full[l*LW +: LW] = r[LW-1:0];
    end
    new_w = merge_bytes(old_w, full, be);
  endfunction

  function automatic logic [AVW-1:0] mk_addr(input logic [1:0] op, input logic [AW-1:0] a);
    logic [AVW-1:0] r;
    r = '0;
    r[AW-1:0] = a;
    r[AVW-1 -: 2] = op;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    av_rd = 1'b0;
    av_wr = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_read(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int n;
    av_addr = mk_addr(op, a);
    av_rd = 1'b1;
    av_wr = 1'b0;
    #1;
    n = 0;
    while (cur_wait && n < 8) begin
      step();
      #1;
      n++;
    end
    check_int("rd_wait", n, 0);
    rdq.push_back('{cyc + sel + 1, exp});
    @(negedge clk);
    av_rd = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] op, input logic [AW-1:0] a, input logic [BEW-1:0] be,
                          input logic [DW-1:0] wd, input logic rd_too);
    int n;
    logic [DW-1:0] nw;
    logic clipped;
    av_addr = mk_addr(op, a);
    av_wr = 1'b1;
    av_rd = rd_too;
    av_be = be;
    av_wd = wd;
    #1;
    n = 0;
    while (cur_wait && n < 10) begin
      step();
      #1;
      n++;
    end
    check_int("wr_wait", n, (op == 2'd0) ? 0 : sel + 1);
    @(negedge clk);
    av_wr = 1'b0;
    av_rd = 1'b0;
    ref_rmw(op, ref_mem[a], wd, be, nw, clipped);
    ref_mem[a] = nw;
    if (clipped) exp_sat[sel] = 1'b1;
    check_int("sat_after_wr", int'(cur_sat), int'(exp_sat[sel]));
  endtask

  task automatic clear_sat();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    exp_sat[sel] = 1'b0;
    check_int("sat_clear", int'(cur_sat), 0);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int l = 0; l < NL; l++) begin
      case ($urandom_range(0, 3))
        0: w[l*LW +: LW] = $urandom;
        1: w[l*LW +: LW] = 32'h7FFFFF00 | 32'($urandom_range(0, 255));
        2: w[l*LW +: LW] = 32'h80000000 | 32'($urandom_range(0, 255));
        default: w[l*LW +: LW] = 32'($urandom_range(0, 15));
      endcase
    end
    return w;
  endfunction

  typedef struct {
    logic [1:0]     op;
    logic [DW-1:0]  init;
    logic [DW-1:0]  wd;
    logic [BEW-1:0] be;
    logic [DW-1:0]  exp;
    logic           exp_sat;
  } vec_t;
  vec_t tbl [9];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int wr_seen;
    logic [1:0] op;
    logic [AW-1:0] a;
    logic [BEW-1:0] be;

    tbl[0] = '{2'd1, {4{32'h00000010}}, {4{32'h00000005}}, 16'hFFFF, {4{32'h00000015}}, 1'b0};
    tbl[1] = '{2'd2, {32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFFFFF0},
               {32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000003}, 16'h0003,
               {32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFF0003}, 1'b0};
    tbl[2] = '{2'd3, {32'h00000000, 32'h00000000, 32'h00000000, 32'h7FFFFFF0},
               {32'h00000001, 32'h00000001, 32'h00000001, 32'h00000100}, 16'hFFFF,
               {32'h00000001, 32'h00000001, 32'h00000001, 32'h7FFFFFFF}, 1'b1};
    tbl[3] = '{2'd3, {32'h00000005, 32'h00000000, 32'h00000000, 32'h80000010},
               {32'h00000003, 32'h00000000, 32'h00000000, 32'hFFFFFF00}, 16'hFFFF,
               {32'h00000008, 32'h00000000, 32'h00000000, 32'h80000000}, 1'b1};
    tbl[4] = '{2'd1, {4{32'hFFFFFFFF}}, {4{32'h00000002}}, 16'hFFFF, {4{32'h00000001}}, 1'b0};
    tbl[5] = '{2'd2, {32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
               {32'h80000000, 32'hFFFFFFFB, 32'h00000001, 32'h7FFFFFFF}, 16'hFFFF,
               {32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFF}, 1'b0};
    tbl[6] = '{2'd0, {4{32'hAAAAAAAA}}, {4{32'h55555555}}, 16'h00F0,
               {32'hAAAAAAAA, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA}, 1'b0};
    tbl[7] = '{2'd3, {32'h00000000, 32'h00000000, 32'h7FFFFFF0, 32'h00000001},
               {32'h00000000, 32'h00000000, 32'h00000100, 32'h00000001}, 16'h000F,
               {32'h00000000, 32'h00000000, 32'h7FFFFFF0, 32'h00000002}, 1'b0};
    tbl[8] = '{2'd3, {4{32'h7FFFFFF0}}, {4{32'h0000000F}}, 16'hFFFF, {4{32'h7FFFFFFF}}, 1'b0};
    for (int k = 0; k < NI; k++) exp_sat[k] = 1'b0;

    // Reset state for every instance.
    @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check_int("rst_wait", int'(wait_a[k]), 1);
      check_int("rst_rvalid", int'(rvalid_a[k]), 0);
      check_int("rst_rden", int'(rden_a[k]), 0);
      check_int("rst_wren", int'(wren_a[k]), 0);
      check_int("rst_sat", int'(sat_a[k]), 0);
      check_vec("rst_sram_addr", DW'(saddr_a[k]), '0);
    end
    @(negedge clk);
    rstn = 1'b1;
    idle(3);
    for (int k = 0; k < NI; k++) check_int("post_rst_wait", int'(wait_a[k]), 0);

    // Table vectors on each read latency.
    for (int s = 0; s < NI; s++) begin
      sel = s;
      for (int i = 0; i < 9; i++) begin
        a = AW'(16 + i);
        clear_sat();
        do_write(2'd0, a, 16'hFFFF, tbl[i].init, 1'b0);
        do_write(tbl[i].op, a, tbl[i].be, tbl[i].wd, 1'b0);
        check_int("tbl_sat", int'(cur_sat), int'(tbl[i].exp_sat));
        do_read(2'd0, a, tbl[i].exp);
        idle(4);
      end
    end

    // Back-to-back reads, RD_LAT=2.
    sel = 1;
    do_write(2'd0, 9'h005, 16'hFFFF, {4{32'h05050505}}, 1'b0);
    do_write(2'd0, 9'h006, 16'hFFFF, {4{32'h06060606}}, 1'b0);
    do_write(2'd0, 9'h007, 16'hFFFF, {4{32'h07070707}}, 1'b0);
    idle(1);
    do_read(2'd0, 9'h005, {4{32'h05050505}});
    do_read(2'd0, 9'h006, {4{32'h06060606}});
    do_read(2'd0, 9'h007, {4{32'h07070707}});
    idle(5);
    check_int("burst_drained", rdq.size(), 0);

    // Same-cycle clear loses to set; a later clear wins.
    sel = 0;
    clear_sat();
    do_write(2'd0, 9'h030, 16'hFFFF, {4{32'h7FFFFFF0}}, 1'b0);
    sat_clr = 1'b1;
    do_write(2'd3, 9'h030, 16'hFFFF, {4{32'h00000100}}, 1'b0);
    check_int("sat_set_beats_clr", int'(cur_sat), 1);
    step();
    sat_clr = 1'b0;
    exp_sat[0] = 1'b0;
    check_int("sat_late_clr", int'(cur_sat), 0);

    // Read / ADD / read hazard.
    for (int s = 0; s < NI; s += 2) begin
      sel = s;
      do_write(2'd0, 9'h040, 16'hFFFF, {4{32'h00000100}}, 1'b0);
      idle(2);
      do_read(2'd0, 9'h040, ref_mem[9'h040]);
      do_write(2'd1, 9'h040, 16'hFFFF, {4{32'h00000001}}, 1'b0);
      do_read(2'd0, 9'h040, ref_mem[9'h040]);
      idle(5);
      check_vec("hazard_model", ref_mem[9'h040], {4{32'h00000101}});
      check_int("hazard_drained", rdq.size(), 0);
    end

    // Reset during RMW_WAIT, RD_LAT=3.
    sel = 2;
    do_write(2'd0, 9'h050, 16'hFFFF, {4{32'h12345678}}, 1'b0);
    do_write(2'd0, 9'h051, 16'hFFFF, {4{32'h7FFFFFFF}}, 1'b0);
    do_write(2'd3, 9'h051, 16'hFFFF, {4{32'h00000001}}, 1'b0);
    idle(2);
    av_addr = mk_addr(2'd1, 9'h050);
    av_be = 16'hFFFF;
    av_wd = {4{32'h00000001}};
    av_wr = 1'b1;
    step();
    rstn = 1'b0;
    av_wr = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (cur_wren) wr_seen++;
      if (i == 1) check_int("rst_mid_wait", int'(cur_wait), 1);
      if (i == 2) rstn = 1'b1;
      @(negedge clk);
    end
    for (int k = 0; k < NI; k++) exp_sat[k] = 1'b0;
    check_int("rst_mid_no_wr", wr_seen, 0);
    #1;
    check_int("rst_mid_wait_low", int'(cur_wait), 0);
    check_int("rst_mid_sat", int'(cur_sat), 0);
    @(negedge clk);
    do_read(2'd0, 9'h050, {4{32'h12345678}});
    idle(5);

    // Random traffic against the lane model.
    for (int s = 0; s < NI; s++) begin
      sel = s;
      for (int i = 0; i < 8; i++) do_write(2'd0, AW'(i), 16'hFFFF, rand_word(), 1'b0);
      for (int it = 0; it < 60; it++) begin
        a = AW'($urandom_range(0, 7));
        op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0, 1, 2, 3: do_read(op, a, ref_mem[a]);
          4: begin
            av_rd = 1'b0;
            av_wr = 1'b0;
            clear_sat();
          end
          default: begin
            case ($urandom_range(0, 2))
              0: be = 16'hFFFF;
              1: be = 16'h000F;
              default: be = BEW'($urandom);
            endcase
            do_write(op, a, be, rand_word(), ($urandom_range(0, 9) == 0));
          end
        endcase
      end
      idle(6);
      check_int("rand_drained", rdq.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
